// File: rtl/add_pkg.sv
// -----------------------------------------------------------------------------
// add_pkg
// Shared definitions for the slice-serial 32-bit adder (add32_seq).
//   WORD_W        : operand width in bits.
//   SLICE_W_LEGAL : bit n set means a slice width of n bits is supported.
//   state_t       : controller states IDLE -> RUN -> DONE.
// -----------------------------------------------------------------------------
package add_pkg;

    localparam int WORD_W = 32;

    // Legal slice widths: 1, 2, 4, 8, 16 and 32 bits.
    localparam logic [WORD_W:0] SLICE_W_LEGAL = 33'h1_0001_0116;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add32_seq_fa_slice.sv
// -----------------------------------------------------------------------------
// fa_slice
// Combinational W-bit ripple-carry adder. One slice of the sequential adder;
// the same instance is reused on every RUN cycle.
// Ports:
//   i_a, i_b : W-bit operand slices
//   i_cin    : carry into bit 0 of the slice
//   o_s      : W-bit slice sum
//   o_cout   : carry out of the slice's top bit
// -----------------------------------------------------------------------------
module fa_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_s,
    output logic         o_cout
);

    logic w_c;

    always_comb begin
        o_s = '0;
        w_c = i_cin;
        for (int i = 0; i < W; i++) begin
            o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end

endmodule

// File: rtl/add32_seq.sv
// -----------------------------------------------------------------------------
// add32_seq
// Slice-serial 32-bit adder: {cout,s} = a + b + cin, SLICE_W bits per cycle.
// A start accepted in IDLE captures the operands; RUN takes 32/SLICE_W cycles,
// then DONE lasts one cycle with done high. s/cout (and ovf) hold in IDLE.
// Optional feature macro: ADD32_SEQ_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : operation request, sampled only in IDLE
//   a, b, cin    : operands, captured on the accepting edge
//   s, cout      : registered sum and carry-out of bit 31
//   busy         : high while in RUN
//   done         : one-cycle completion pulse (state DONE)
//   ovf          : signed overflow (only with ADD32_SEQ_OVF_EN)
// -----------------------------------------------------------------------------
module add32_seq
    import add_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] s,
    output logic              cout,
    output logic              busy,
    output logic              done
`ifdef ADD32_SEQ_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam int NSLICE = WORD_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int SH_W   = $clog2(WORD_W);

    if (!SLICE_W_LEGAL[SLICE_W]) begin : g_bad_slice_w
        $error("add32_seq: SLICE_W must be 1, 2, 4, 8, 16 or 32");
    end

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic [WORD_W-1:0]   r_a;
    logic [WORD_W-1:0]   r_b;
    logic [WORD_W-1:0]   r_s;
    logic                r_cout;
`ifdef ADD32_SEQ_OVF_EN
    logic                r_ovf;
`endif

    logic                w_accept;
    logic                w_last;
    logic [SH_W-1:0]     w_sh;
    logic [SLICE_W-1:0]  w_a_sl;
    logic [SLICE_W-1:0]  w_b_sl;
    logic [SLICE_W-1:0]  w_sum;
    logic                w_cout;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_idx == IDX_W'(NSLICE - 1));
    // Bit offset of the current slice; always 0 when there is a single slice.
    assign w_sh     = SH_W'(r_idx) * SH_W'(SLICE_W);
    assign w_a_sl   = r_a[w_sh +: SLICE_W];
    assign w_b_sl   = r_b[w_sh +: SLICE_W];

    fa_slice #(
        .W      (SLICE_W)
    ) u_fa_slice (
        .i_a    (w_a_sl),
        .i_b    (w_b_sl),
        .i_cin  (r_carry),
        .o_s    (w_sum),
        .o_cout (w_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

    // Operand capture; operands are only consumed after a capture, so no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= b;
        end
    end

    // Slice datapath: one slice of s per RUN cycle, carry chained through r_carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
`ifdef ADD32_SEQ_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_carry <= cin;
                    end
                end
                RUN: begin
                    r_s[w_sh +: SLICE_W] <= w_sum;
                    r_carry              <= w_cout;
                    r_idx                <= r_idx + IDX_W'(1);
                    // cout/ovf only change on the final slice so they hold like s.
                    if (w_last) begin
                        r_cout <= w_cout;
`ifdef ADD32_SEQ_OVF_EN
                        r_ovf  <= (r_a[WORD_W-1] == r_b[WORD_W-1]) &&
                                  (w_sum[SLICE_W-1] != r_a[WORD_W-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
`ifdef ADD32_SEQ_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_add32_seq.sv
// -----------------------------------------------------------------------------
// tb_add32_seq
// Self-checking bench for add32_seq. Inputs are driven and outputs sampled
// 1 ns after each rising edge. The reference result is plain 33-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_add32_seq;

    localparam int SLICE_W = 8;
    localparam int NSLICE  = 32 / SLICE_W;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        cin   = 1'b0;
    logic [31:0] s;
    logic        cout;
    logic        busy;
    logic        done;
`ifdef ADD32_SEQ_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    add32_seq #(
        .SLICE_W (SLICE_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
`ifdef ADD32_SEQ_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation from IDLE and waits (bounded) for done.
    // lat = number of edges after the accepting edge until done is seen.
    // scramble: random operands/start during RUN; otherwise operands go to 0.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          input logic ic, input bit scramble, output int lat);
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        tick();
        lat   = 0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            if (scramble) begin
                a     = $urandom;
                b     = $urandom;
                cin   = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b1;
        a     = 32'hDEADBEEF;
        b     = 32'h12345678;
        repeat (3) tick();
        n_checks++;
        if (s !== 32'h0) begin n_fail++; $display("FAIL reset_s: got %h expected %h", s, 32'h0); end
        n_checks++;
        if ({cout, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got cout/busy/done=%b expected 000", {cout, busy, done}); end
`ifdef ADD32_SEQ_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_carry_wrap();
        int lat;
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat !== NSLICE) begin n_fail++; $display("FAIL wrap_latency: got %0d expected %0d", lat, NSLICE); end
        n_checks++;
        if (s !== 32'h0) begin n_fail++; $display("FAIL wrap_s: got %h expected %h", s, 32'h0); end
        n_checks++;
        if (cout !== 1'b1) begin n_fail++; $display("FAIL wrap_cout: got %b expected 1", cout); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_busy_in_done: got %b expected 0", busy); end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL wrap_done_width: got %b expected 0", done); end
        n_checks++;
        if ({cout, s} !== 33'h1_0000_0000) begin n_fail++; $display("FAIL wrap_hold: got %h expected %h", {cout, s}, 33'h1_0000_0000); end
    endtask

    task automatic test_operand_change();
        int lat;
        run_op(32'h12345678, 32'h11111111, 1'b1, 1'b0, lat);
        n_checks++;
        if (lat !== NSLICE) begin n_fail++; $display("FAIL opchg_latency: got %0d expected %0d", lat, NSLICE); end
        n_checks++;
        if (s !== 32'h2345678A) begin n_fail++; $display("FAIL opchg_s: got %h expected %h", s, 32'h2345678A); end
        n_checks++;
        if (cout !== 1'b0) begin n_fail++; $display("FAIL opchg_cout: got %b expected 0", cout); end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL opchg_done_width: got %b expected 0", done); end
    endtask

    task automatic test_start_held();
        int pulses = 0;
        int d1 = -1;
        int d2 = -1;
        a     = 32'h1;
        b     = 32'h1;
        cin   = 1'b0;
        start = 1'b1;
        // Edge c=1 is the accepting edge.
        for (int c = 1; c <= 2 * NSLICE + 4; c++) begin
            tick();
            if (done === 1'b1) begin
                pulses++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
                n_checks++;
                if (s !== 32'h2) begin n_fail++; $display("FAIL held_s: got %h expected %h", s, 32'h2); end
            end
        end
        start = 1'b0;
        n_checks++;
        if (pulses !== 2) begin n_fail++; $display("FAIL held_pulses: got %0d expected %0d", pulses, 2); end
        n_checks++;
        if (d1 !== NSLICE + 1) begin n_fail++; $display("FAIL held_first_done: got edge %0d expected %0d", d1, NSLICE + 1); end
        n_checks++;
        if (d2 - d1 !== NSLICE + 2) begin n_fail++; $display("FAIL held_spacing: got %0d expected %0d", d2 - d1, NSLICE + 2); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen_done = 0;
        a     = 32'hFFFFFFFF;
        b     = 32'hFFFFFFFF;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (s !== 32'h0) begin n_fail++; $display("FAIL midrst_s: got %h expected %h", s, 32'h0); end
        n_checks++;
        if ({cout, busy, done} !== 3'b000) begin n_fail++; $display("FAIL midrst_ctl: got cout/busy/done=%b expected 000", {cout, busy, done}); end
`ifdef ADD32_SEQ_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf: got %b expected 0", ovf); end
`endif
        for (int i = 0; i < NSLICE + 2; i++) begin
            tick();
            if (done === 1'b1) seen_done++;
            if (i == 1) rst_n = 1'b1;
        end
        n_checks++;
        if (seen_done !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", seen_done); end
        run_op(32'd5, 32'd7, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat !== NSLICE) begin n_fail++; $display("FAIL midrst_next_latency: got %0d expected %0d", lat, NSLICE); end
        n_checks++;
        if ({cout, s} !== 33'd12) begin n_fail++; $display("FAIL midrst_next_sum: got %h expected %h", {cout, s}, 33'd12); end
        tick();
    endtask

`ifdef ADD32_SEQ_OVF_EN
    task automatic test_ovf();
        int lat;
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
        n_checks++;
        if ({ovf, cout, s} !== {1'b1, 1'b0, 32'h80000000}) begin
            n_fail++; $display("FAIL ovf_pos: got ovf/cout/s=%b/%b/%h expected 1/0/80000000", ovf, cout, s);
        end
        tick();
        n_checks++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %b expected 1", ovf); end
        run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, lat);
        n_checks++;
        if ({ovf, cout, s} !== {1'b1, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL ovf_neg: got ovf/cout/s=%b/%b/%h expected 1/1/00000000", ovf, cout, s);
        end
        tick();
        run_op(32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b0, lat);
        n_checks++;
        if ({ovf, cout, s} !== {1'b0, 1'b1, 32'h2}) begin
            n_fail++; $display("FAIL ovf_none: got ovf/cout/s=%b/%b/%h expected 0/1/00000002", ovf, cout, s);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        int          lat;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] exp_sum;
        for (int n = 0; n < 200; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            case (n % 8)
                0: ra = 32'hFFFFFFFF;
                1: begin ra = 32'h80000000; rb = 32'h80000000; end
                default: ;
            endcase
            exp_sum = 33'(ra) + 33'(rb) + 33'(rc);
            run_op(ra, rb, rc, 1'b1, lat);
            n_checks++;
            if (lat !== NSLICE) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, NSLICE); end
            n_checks++;
            if ({cout, s} !== exp_sum) begin
                n_fail++; $display("FAIL rand_sum[%0d]: a=%h b=%h cin=%b got %h expected %h", n, ra, rb, rc, {cout, s}, exp_sum);
            end
`ifdef ADD32_SEQ_OVF_EN
            n_checks++;
            if (ovf !== ((ra[31] == rb[31]) && (exp_sum[31] != ra[31]))) begin
                n_fail++; $display("FAIL rand_ovf[%0d]: got %b expected %b", n, ovf, (ra[31] == rb[31]) && (exp_sum[31] != ra[31]));
            end
`endif
            tick();
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL rand_done_width[%0d]: got %b expected 0", n, done); end
            repeat ($urandom_range(0, 2)) begin
                a = $urandom;
                b = $urandom;
                tick();
            end
            n_checks++;
            if ({cout, s} !== exp_sum) begin
                n_fail++; $display("FAIL rand_idle_hold[%0d]: got %h expected %h", n, {cout, s}, exp_sum);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_carry_wrap();
        test_operand_change();
        test_start_held();
        test_reset_mid_run();
`ifdef ADD32_SEQ_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
